// File: rtl/prng_lfsr_stream.sv
// Fibonacci-LFSR pseudo-random word generator with a valid/ready output stream,
// zero-seed substitution, lock-up recovery, post-seed warm-up and a draw counter.
module prng_lfsr_stream #(
  parameter int unsigned      WIDTH        = 128,
  parameter int unsigned      WARMUP       = 0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [WIDTH-1:0] rand_num,
  output logic             zero_seed_err,
  output logic             lockup,
  output logic [31:0]      draw_cnt
);

  typedef enum logic [1:0] {
    S_UNSEEDED = 2'd0,
    S_WARM     = 2'd1,
    S_RUN      = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [15:0]      warm_q, warm_d;
  logic [31:0]      draw_q, draw_d;
  logic             zerr_q, zerr_d;
  logic             lock_q, lock_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] step_safe;
  logic             step_zero;

  // An all-zero successor would freeze the LFSR, so it is replaced by the default seed.
  assign step_val  = {state_q[WIDTH-2:0], ^(poly & state_q)};
  assign step_zero = (step_val == '0);
  assign step_safe = step_zero ? DEFAULT_SEED : step_val;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    warm_d  = warm_q;
    draw_d  = draw_q;
    zerr_d  = zerr_q;
    lock_d  = 1'b0;

    if (seed_valid) begin
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
      zerr_d  = (seed == '0);
      draw_d  = '0;
      warm_d  = 16'(WARMUP);
      fsm_d   = (WARMUP > 0) ? S_WARM : S_RUN;
    end else begin
      case (fsm_q)
        S_WARM: begin
          state_d = step_safe;
          lock_d  = step_zero;
          warm_d  = warm_q - 16'd1;
          if (warm_q == 16'd1) fsm_d = S_RUN;
        end
        S_RUN: begin
          if (rand_ready) begin
            state_d = step_safe;
            lock_d  = step_zero;
            draw_d  = draw_q + 32'd1;
          end
        end
        default: ;
      endcase
    end

    valid_d = (fsm_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_UNSEEDED;
      state_q <= '0;
      warm_q  <= '0;
      draw_q  <= '0;
      zerr_q  <= 1'b0;
      lock_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      warm_q  <= warm_d;
      draw_q  <= draw_d;
      zerr_q  <= zerr_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
    end
  end

  assign rand_valid    = valid_q;
  assign rand_num      = state_q;
  assign zero_seed_err = zerr_q;
  assign lockup        = lock_q;
  assign draw_cnt      = draw_q;

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// Bench for prng_lfsr_stream: two 8-bit instances (no warm-up, 3-step warm-up) driven
// by shared stimulus and compared every cycle against a behavioural model.
module tb_prng_lfsr_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seed_valid = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] poly = 8'h00;
  logic       rand_ready = 1'b0;

  logic       valid[2];
  logic [7:0] num[2];
  logic       zerr[2];
  logic       lock[2];
  logic [31:0] draw[2];

  int n_chk = 0;
  int n_err = 0;

  // model state, one entry per instance; phase 0 = unseeded, 1 = warming, 2 = running
  int          warm_of[2] = '{0, 3};
  logic [7:0]  m_state[2];
  int          m_phase[2];
  int          m_left[2];
  logic [31:0] m_draw[2];
  logic        m_zerr[2];
  logic        m_lock[2];

  always #5 clk = ~clk;

  prng_lfsr_stream #(.WIDTH(8), .WARMUP(0)) u_dut0 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .poly(poly),
    .rand_valid(valid[0]), .rand_ready(rand_ready), .rand_num(num[0]),
    .zero_seed_err(zerr[0]), .lockup(lock[0]), .draw_cnt(draw[0])
  );

  prng_lfsr_stream #(.WIDTH(8), .WARMUP(3)) u_dut1 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .poly(poly),
    .rand_valid(valid[1]), .rand_ready(rand_ready), .rand_num(num[1]),
    .zero_seed_err(zerr[1]), .lockup(lock[1]), .draw_cnt(draw[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // shift left, new low bit = parity of tapped bits, recovering from zero
  task automatic model_adv(input int d, input logic [7:0] p);
    int nxt;
    nxt = ((int'(m_state[d]) * 2) % 256) + ($countones(p & m_state[d]) % 2);
    if (nxt == 0) begin
      m_state[d] = 8'h01;
      m_lock[d]  = 1'b1;
    end else begin
      m_state[d] = 8'(nxt);
    end
  endtask

  task automatic model_edge(input int d, input logic r, input logic sv, input logic [7:0] sd,
                            input logic [7:0] p, input logic rdy);
    m_lock[d] = 1'b0;
    if (r) begin
      m_state[d] = 8'h00; m_phase[d] = 0; m_left[d] = 0;
      m_draw[d] = 0; m_zerr[d] = 1'b0;
    end else if (sv) begin
      m_state[d] = (sd == 8'h00) ? 8'h01 : sd;
      m_zerr[d]  = (sd == 8'h00);
      m_draw[d]  = 0;
      m_left[d]  = warm_of[d];
      m_phase[d] = (warm_of[d] > 0) ? 1 : 2;
    end else if (m_phase[d] == 1) begin
      model_adv(d, p);
      m_left[d]--;
      if (m_left[d] == 0) m_phase[d] = 2;
    end else if (m_phase[d] == 2 && rdy) begin
      model_adv(d, p);
      m_draw[d]++;
    end
  endtask

  task automatic tick();
    logic r, sv, rdy;
    logic [7:0] sd, p;
    r = rst; sv = seed_valid; sd = seed; p = poly; rdy = rand_ready;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, r, sv, sd, p, rdy);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid%0d", d), 32'(valid[d]), 32'(m_phase[d] == 2));
      chk($sformatf("num%0d", d),   32'(num[d]),   32'(m_state[d]));
      chk($sformatf("zerr%0d", d),  32'(zerr[d]),  32'(m_zerr[d]));
      chk($sformatf("lock%0d", d),  32'(lock[d]),  32'(m_lock[d]));
      chk($sformatf("draw%0d", d),  draw[d],       m_draw[d]);
    end
  endtask

  task automatic load(input logic [7:0] sd);
    seed = sd; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_num;
    int lock_seen;

    // reset, then idle with ready high
    tick();
    rst = 1'b0; rand_ready = 1'b1;
    repeat (5) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(valid[d]), 32'h0);
      chk("rst_num",   32'(num[d]),   32'h0);
      chk("rst_draw",  draw[d],       32'h0);
      chk("rst_zerr",  32'(zerr[d]),  32'h0);
      chk("rst_lock",  32'(lock[d]),  32'h0);
    end

    // pure rotate on the no-warm-up instance
    poly = 8'h80;
    load(8'h01);
    chk("rot_first", 32'(num[0]), 32'h01);
    chk("rot_valid", 32'(valid[0]), 32'h1);
    lock_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_num = 8'(1 << (i % 8));
      chk($sformatf("rot_seq%0d", i), 32'(num[0]), 32'(exp_num));
      if (lock[0]) lock_seen++;
    end
    chk("rot_draw", draw[0], 32'd9);
    chk("rot_nolock", 32'(lock_seen), 32'd0);

    // zero seed substitution, then cleared by a non-zero seed
    rand_ready = 1'b0;
    load(8'h00);
    chk("zs_num", 32'(num[0]), 32'h01);
    chk("zs_err", 32'(zerr[0]), 32'h1);
    load(8'h05);
    chk("zs_clr", 32'(zerr[0]), 32'h0);
    chk("zs_num5", 32'(num[0]), 32'h05);

    // lock-up recovery
    poly = 8'h00;
    load(8'h80);
    rand_ready = 1'b1;
    tick();
    chk("lk_num", 32'(num[0]), 32'h01);
    chk("lk_pulse", 32'(lock[0]), 32'h1);
    rand_ready = 1'b0;
    tick();
    chk("lk_end", 32'(lock[0]), 32'h0);

    // warm-up then stall on the 3-step instance
    poly = 8'h80;
    load(8'h01);
    chk("wu_v0", 32'(valid[1]), 32'h0);
    tick();
    chk("wu_v1", 32'(valid[1]), 32'h0);
    tick();
    chk("wu_v2", 32'(valid[1]), 32'h0);
    tick();
    chk("wu_valid", 32'(valid[1]), 32'h1);
    chk("wu_num", 32'(num[1]), 32'h08);
    repeat (4) tick();
    chk("st_num", 32'(num[1]), 32'h08);
    chk("st_draw", draw[1], 32'h0);

    // reseed during continuous ready
    rand_ready = 1'b1;
    repeat (3) tick();
    load(8'h10);
    chk("rs_num", 32'(num[0]), 32'h10);
    chk("rs_draw", draw[0], 32'h0);
    chk("rs_wvalid", 32'(valid[1]), 32'h0);
    tick();
    chk("rs_num2", 32'(num[0]), 32'h20);
    chk("rs_draw2", draw[0], 32'h1);

    // reset beats a simultaneous seed load
    rst = 1'b1; seed_valid = 1'b1; seed = 8'h33;
    tick();
    rst = 1'b0; seed_valid = 1'b0;
    chk("rsv_num", 32'(num[0]), 32'h0);
    chk("rsv_valid", 32'(valid[0]), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      seed_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       seed = 8'h00;
        1:       seed = 8'h80;
        default: seed = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) poly = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      rand_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
